// File: rtl/ssio_sdr_in_framed.sv
// Source-synchronous SDR input capture with retiming, lane masking and frame/gap checking.
// Define SSIO_SDR_IN_STATS_EN to build the frame/error statistics counters.
`timescale 1ns/1ps

module ssio_sdr_in_framed #(
  parameter int LANES       = 4,
  parameter int LANE_WIDTH  = 1,
  parameter int PIPE_STAGES = 1,
  parameter int MIN_GAP     = 12
) (
  input  logic                        input_clk,
  input  logic                        rst_n,
  input  logic [LANES*LANE_WIDTH-1:0] input_d,
  input  logic                        input_dv,
  input  logic [LANES-1:0]            lane_en,
  output logic [LANES*LANE_WIDTH-1:0] output_q,
  output logic                        output_dv,
  output logic                        output_sof,
  output logic                        output_eof,
  output logic [15:0]                 output_frame_len,
  output logic                        gap_err,
  output logic [31:0]                 stat_frames,
  output logic [31:0]                 stat_errors
);

  localparam int W = LANES * LANE_WIDTH;
  localparam logic [7:0] GAP_TGT = 8'(MIN_GAP);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DROP} state_t;

  logic [W-1:0] lane_mask;
  logic [W-1:0] s_d;
  logic         s_dv;
  logic         eof;

  state_t       state;
  logic [7:0]   gap_cnt;
  logic [W-1:0] q_reg;
  logic         dv_reg;
  logic         sof_reg;
  logic         err_reg;
  logic [15:0]  len_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mask
    assign lane_mask[gi*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{lane_en[gi]}};
  end

  // Stage 0 is the capture register fed straight from the pins; the rest only retime.
  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    logic [W-1:0] d;
    logic         dv;
    if (gi == 0) begin : g_cap
      always_ff @(posedge input_clk or negedge rst_n) begin
        if (!rst_n) begin
          d  <= '0;
          dv <= 1'b0;
        end else begin
          d  <= input_d;
          dv <= input_dv;
        end
      end
    end else begin : g_ret
      always_ff @(posedge input_clk or negedge rst_n) begin
        if (!rst_n) begin
          d  <= '0;
          dv <= 1'b0;
        end else begin
          d  <= g_stage[gi-1].d;
          dv <= g_stage[gi-1].dv;
        end
      end
    end
  end

  assign s_d  = g_stage[PIPE_STAGES-1].d;
  assign s_dv = g_stage[PIPE_STAGES-1].dv;

  // The output register acts as the lookahead stage: the word it holds is the
  // last of its frame exactly when the word now behind it is not valid.
  assign eof = dv_reg & ~s_dv;

  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
      q_reg   <= '0;
      dv_reg  <= 1'b0;
      sof_reg <= 1'b0;
      err_reg <= 1'b0;
      len_reg <= 16'd0;
    end else begin
      q_reg   <= '0;
      dv_reg  <= 1'b0;
      sof_reg <= 1'b0;
      err_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (s_dv) begin
            state   <= ACTIVE;
            q_reg   <= s_d & lane_mask;
            dv_reg  <= 1'b1;
            sof_reg <= 1'b1;
            len_reg <= 16'd1;
          end
        end
        ACTIVE: begin
          if (s_dv) begin
            q_reg  <= s_d & lane_mask;
            dv_reg <= 1'b1;
            if (len_reg != 16'hFFFF) len_reg <= len_reg + 16'd1;
          end else begin
            // The idle cycle that ends the frame is the first one of the gap.
            gap_cnt <= 8'd1;
            state   <= (GAP_TGT == 8'd1) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (s_dv) begin
            err_reg <= 1'b1;
            state   <= DROP;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
            if (gap_cnt + 8'd1 == GAP_TGT) state <= IDLE;
          end
        end
        DROP: begin
          if (!s_dv) begin
            gap_cnt <= 8'd1;
            state   <= (GAP_TGT == 8'd1) ? IDLE : GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign output_q         = q_reg;
  assign output_dv        = dv_reg;
  assign output_sof       = sof_reg;
  assign output_eof       = eof;
  assign output_frame_len = len_reg;
  assign gap_err          = err_reg;

`ifdef SSIO_SDR_IN_STATS_EN
  logic [31:0] frames_reg;
  logic [31:0] errors_reg;

  always_ff @(posedge input_clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_reg <= 32'd0;
      errors_reg <= 32'd0;
    end else begin
      if (eof)     frames_reg <= frames_reg + 32'd1;
      if (err_reg) errors_reg <= errors_reg + 32'd1;
    end
  end

  assign stat_frames = frames_reg;
  assign stat_errors = errors_reg;
`else
  assign stat_frames = 32'd0;
  assign stat_errors = 32'd0;
`endif

endmodule

// File: tb/tb_ssio_sdr_in_framed.sv
// Directed bench for ssio_sdr_in_framed: default instance (PIPE_STAGES=1) plus a PIPE_STAGES=4 instance.
`timescale 1ns/1ps

module tb_ssio_sdr_in_framed;

`ifdef SSIO_SDR_IN_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] input_d = 4'd0;
  logic       input_dv = 1'b0;
  logic [3:0] lane_en = 4'b1111;

  logic [3:0]  q1, q4;
  logic        dv1, dv4, sof1, sof4, eof1, eof4, err1, err4;
  logic [15:0] len1, len4;
  logic [31:0] sf1, se1, sf4, se4;

  int n_cmp = 0;
  int n_bad = 0;

  logic       stim_dv [64];
  logic [3:0] stim_d  [64];
  logic       ob_dv [64], ob_sof [64], ob_eof [64], ob_err [64];
  logic [3:0] ob_q  [64];
  logic [15:0] ob_len [64];
  logic       ob4_dv [64], ob4_sof [64], ob4_eof [64];
  logic [3:0] ob4_q  [64];
  logic [15:0] ob4_len [64];

  always #5 clk = ~clk;

  ssio_sdr_in_framed u_dut (
    .input_clk(clk), .rst_n(rst_n), .input_d(input_d), .input_dv(input_dv), .lane_en(lane_en),
    .output_q(q1), .output_dv(dv1), .output_sof(sof1), .output_eof(eof1),
    .output_frame_len(len1), .gap_err(err1), .stat_frames(sf1), .stat_errors(se1)
  );

  ssio_sdr_in_framed #(.PIPE_STAGES(4)) u_dut4 (
    .input_clk(clk), .rst_n(rst_n), .input_d(input_d), .input_dv(input_dv), .lane_en(lane_en),
    .output_q(q4), .output_dv(dv4), .output_sof(sof4), .output_eof(eof4),
    .output_frame_len(len4), .gap_err(err4), .stat_frames(sf4), .stat_errors(se4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    input_dv = 1'b0;
    input_d = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      stim_dv[i] = 1'b0;
      stim_d[i]  = 4'hA;  // garbage on idle cycles must never reach output_q
    end
  endtask

  task automatic put_frame(input int start, input int n, input logic [3:0] first);
    for (int i = 0; i < n; i++) begin
      stim_dv[start+i] = 1'b1;
      stim_d[start+i]  = first + 4'(i);
    end
  endtask

  // Drive stimulus slots from..to; after the tick of slot c the outputs are logged at index c.
  task automatic run(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      input_dv = stim_dv[c];
      input_d  = stim_d[c];
      tick();
      ob_dv[c] = dv1;  ob_q[c] = q1;  ob_sof[c] = sof1;  ob_eof[c] = eof1;
      ob_len[c] = len1; ob_err[c] = err1;
      ob4_dv[c] = dv4; ob4_q[c] = q4; ob4_sof[c] = sof4; ob4_eof[c] = eof4; ob4_len[c] = len4;
    end
    $display("run slots %0d..%0d done", from, to);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    input_dv = 1'b1;
    input_d = 4'hF;
    tick();
    tick();
    n_cmp++; if (dv1 !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b expected 0", dv1); end
    n_cmp++; if (q1 !== 4'h0) begin n_bad++; $display("FAIL reset_q: got %h expected 0", q1); end
    n_cmp++; if ({sof1, eof1, err1} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {sof1, eof1, err1}); end
    n_cmp++; if (len1 !== 16'd0) begin n_bad++; $display("FAIL reset_len: got %h expected 0", len1); end
    n_cmp++; if ({sf1, se1} !== 64'd0) begin n_bad++; $display("FAIL reset_stats: got %h expected 0", {sf1, se1}); end
    n_cmp++; if ({dv4, sof4, eof4, q4} !== 7'd0) begin n_bad++; $display("FAIL reset_p4: got %h expected 0", {dv4, sof4, eof4, q4}); end
    input_dv = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic       e_dv;
    logic [3:0] e_q;
    do_reset();
    clear_stim();
    put_frame(2, 5, 4'h1);
    run(0, 12);
    for (int c = 0; c <= 10; c++) begin
      e_dv = (c >= 3 && c <= 7);
      e_q  = e_dv ? 4'(c - 2) : 4'h0;
      n_cmp++; if (ob_dv[c] !== e_dv) begin n_bad++; $display("FAIL basic_dv c=%0d: got %b expected %b", c, ob_dv[c], e_dv); end
      n_cmp++; if (ob_q[c] !== e_q) begin n_bad++; $display("FAIL basic_q c=%0d: got %h expected %h", c, ob_q[c], e_q); end
      n_cmp++; if (ob_sof[c] !== (c == 3)) begin n_bad++; $display("FAIL basic_sof c=%0d: got %b expected %b", c, ob_sof[c], (c == 3)); end
      n_cmp++; if (ob_eof[c] !== (c == 7)) begin n_bad++; $display("FAIL basic_eof c=%0d: got %b expected %b", c, ob_eof[c], (c == 7)); end
    end
    n_cmp++; if (ob_len[7] !== 16'd5) begin n_bad++; $display("FAIL basic_len: got %0d expected 5", ob_len[7]); end
    n_cmp++; if (ob4_dv[5] !== 1'b0) begin n_bad++; $display("FAIL p4_early_dv: got %b expected 0", ob4_dv[5]); end
    n_cmp++; if ({ob4_dv[6], ob4_sof[6], ob4_q[6]} !== {2'b11, 4'h1}) begin n_bad++; $display("FAIL p4_first: got %h expected %h", {ob4_dv[6], ob4_sof[6], ob4_q[6]}, {2'b11, 4'h1}); end
    n_cmp++; if ({ob4_eof[9], ob4_eof[10], ob4_len[10]} !== {2'b01, 16'd5}) begin n_bad++; $display("FAIL p4_eof: got %h expected %h", {ob4_eof[9], ob4_eof[10], ob4_len[10]}, {2'b01, 16'd5}); end
  endtask

  task automatic test_back_to_back();
    int errs;
    do_reset();
    clear_stim();
    put_frame(2, 3, 4'h1);
    put_frame(17, 2, 4'h7);  // exactly 12 idle slots between the frames
    run(0, 25);
    errs = 0;
    for (int c = 0; c <= 25; c++) errs += int'(ob_err[c]);
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL b2b_gap_err: got %0d pulses expected 0", errs); end
    n_cmp++; if ({ob_eof[5], ob_len[5]} !== {1'b1, 16'd3}) begin n_bad++; $display("FAIL b2b_eof1: got %h expected %h", {ob_eof[5], ob_len[5]}, {1'b1, 16'd3}); end
    n_cmp++; if ({ob_dv[17], ob_q[17]} !== 5'h00) begin n_bad++; $display("FAIL b2b_idle: got %h expected 0", {ob_dv[17], ob_q[17]}); end
    n_cmp++; if ({ob_dv[18], ob_sof[18], ob_q[18]} !== {2'b11, 4'h7}) begin n_bad++; $display("FAIL b2b_sof2: got %h expected %h", {ob_dv[18], ob_sof[18], ob_q[18]}, {2'b11, 4'h7}); end
    n_cmp++; if ({ob_dv[19], ob_eof[19], ob_q[19], ob_len[19]} !== {2'b11, 4'h8, 16'd2}) begin n_bad++; $display("FAIL b2b_eof2: got %h expected %h", {ob_dv[19], ob_eof[19], ob_q[19], ob_len[19]}, {2'b11, 4'h8, 16'd2}); end
    n_cmp++; if (ob_len[25] !== 16'd2) begin n_bad++; $display("FAIL b2b_len_hold: got %0d expected 2", ob_len[25]); end
    n_cmp++; if (sf1 !== 32'(STATS * 2)) begin n_bad++; $display("FAIL b2b_stat_frames: got %0d expected %0d", sf1, STATS * 2); end
  endtask

  task automatic test_gap_violation();
    int errs;
    do_reset();
    clear_stim();
    put_frame(2, 2, 4'h1);
    put_frame(11, 3, 4'h4);  // only 7 idle slots: dropped
    put_frame(26, 2, 4'h9);  // 12 idle slots after the dropped frame: accepted
    run(0, 31);
    errs = 0;
    for (int c = 0; c <= 31; c++) errs += int'(ob_err[c]);
    n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL gap_err_count: got %0d expected 1", errs); end
    n_cmp++; if (ob_err[12] !== 1'b1) begin n_bad++; $display("FAIL gap_err_pos: got %b expected 1", ob_err[12]); end
    for (int c = 12; c <= 14; c++) begin
      n_cmp++; if ({ob_dv[c], ob_sof[c], ob_eof[c], ob_q[c]} !== 7'd0) begin n_bad++; $display("FAIL gap_drop c=%0d: got %h expected 0", c, {ob_dv[c], ob_sof[c], ob_eof[c], ob_q[c]}); end
    end
    n_cmp++; if (ob_len[14] !== 16'd2) begin n_bad++; $display("FAIL gap_len_hold: got %0d expected 2", ob_len[14]); end
    n_cmp++; if ({ob_dv[27], ob_sof[27], ob_q[27]} !== {2'b11, 4'h9}) begin n_bad++; $display("FAIL gap_third_sof: got %h expected %h", {ob_dv[27], ob_sof[27], ob_q[27]}, {2'b11, 4'h9}); end
    n_cmp++; if ({ob_eof[28], ob_q[28], ob_len[28]} !== {1'b1, 4'hA, 16'd2}) begin n_bad++; $display("FAIL gap_third_eof: got %h expected %h", {ob_eof[28], ob_q[28], ob_len[28]}, {1'b1, 4'hA, 16'd2}); end
    n_cmp++; if (se1 !== 32'(STATS)) begin n_bad++; $display("FAIL gap_stat_errors: got %0d expected %0d", se1, STATS); end
    n_cmp++; if (sf1 !== 32'(STATS * 2)) begin n_bad++; $display("FAIL gap_stat_frames: got %0d expected %0d", sf1, STATS * 2); end
  endtask

  task automatic test_lane_en();
    do_reset();
    lane_en = 4'b0101;
    clear_stim();
    put_frame(2, 1, 4'hF);
    run(0, 8);
    n_cmp++; if ({ob_dv[2], ob_q[2]} !== 5'h00) begin n_bad++; $display("FAIL lane_idle: got %h expected 0", {ob_dv[2], ob_q[2]}); end
    n_cmp++; if (ob_q[3] !== 4'h5) begin n_bad++; $display("FAIL lane_mask: got %h expected 5", ob_q[3]); end
    n_cmp++; if ({ob_dv[3], ob_sof[3], ob_eof[3]} !== 3'b111) begin n_bad++; $display("FAIL lane_one_word: got %b expected 111", {ob_dv[3], ob_sof[3], ob_eof[3]}); end
    n_cmp++; if (ob_len[3] !== 16'd1) begin n_bad++; $display("FAIL lane_len: got %0d expected 1", ob_len[3]); end
    n_cmp++; if ({ob4_sof[6], ob4_eof[6], ob4_q[6]} !== {2'b11, 4'h5}) begin n_bad++; $display("FAIL lane_p4: got %h expected %h", {ob4_sof[6], ob4_eof[6], ob4_q[6]}, {2'b11, 4'h5}); end
    lane_en = 4'b1111;
  endtask

  task automatic test_reset_midframe();
    int bad_eof;
    do_reset();
    clear_stim();
    put_frame(1, 6, 4'h1);
    put_frame(12, 3, 4'hB);
    run(0, 7);
    n_cmp++; if ({ob4_dv[7], ob4_q[7]} !== {1'b1, 4'h3}) begin n_bad++; $display("FAIL mid_word3: got %h expected %h", {ob4_dv[7], ob4_q[7]}, {1'b1, 4'h3}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({dv4, sof4, eof4, q4, len4} !== 23'd0) begin n_bad++; $display("FAIL mid_async_p4: got %h expected 0", {dv4, sof4, eof4, q4, len4}); end
    n_cmp++; if ({dv1, sof1, eof1, q1, len1} !== 23'd0) begin n_bad++; $display("FAIL mid_async_p1: got %h expected 0", {dv1, sof1, eof1, q1, len1}); end
    tick();
    rst_n = 1'b1;
    run(8, 20);
    bad_eof = 0;
    for (int c = 8; c <= 15; c++) bad_eof += int'(ob4_eof[c]) + int'(ob4_dv[c]);
    n_cmp++; if (bad_eof !== 0) begin n_bad++; $display("FAIL mid_discard: got %0d stray dv/eof expected 0", bad_eof); end
    n_cmp++; if ({ob4_dv[16], ob4_sof[16], ob4_q[16]} !== {2'b11, 4'hB}) begin n_bad++; $display("FAIL mid_latency5: got %h expected %h", {ob4_dv[16], ob4_sof[16], ob4_q[16]}, {2'b11, 4'hB}); end
    n_cmp++; if ({ob4_eof[18], ob4_q[18], ob4_len[18]} !== {1'b1, 4'hD, 16'd3}) begin n_bad++; $display("FAIL mid_eof: got %h expected %h", {ob4_eof[18], ob4_q[18], ob4_len[18]}, {1'b1, 4'hD, 16'd3}); end
    n_cmp++; if ({ob_sof[13], ob_q[13]} !== {1'b1, 4'hB}) begin n_bad++; $display("FAIL mid_p1_restart: got %h expected %h", {ob_sof[13], ob_q[13]}, {1'b1, 4'hB}); end
  endtask

  task automatic test_saturation();
    do_reset();
    input_dv = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      input_d = 4'(i);
      tick();
    end
    input_dv = 1'b0;
    tick();
    n_cmp++; if ({dv1, eof1} !== 2'b11) begin n_bad++; $display("FAIL sat_eof: got %b expected 11", {dv1, eof1}); end
    n_cmp++; if (len1 !== 16'hFFFF) begin n_bad++; $display("FAIL sat_len: got %h expected ffff", len1); end
    tick();
    tick();
    n_cmp++; if (len1 !== 16'hFFFF) begin n_bad++; $display("FAIL sat_len_hold: got %h expected ffff", len1); end
    n_cmp++; if (sf1 !== 32'(STATS)) begin n_bad++; $display("FAIL sat_stat_frames: got %0d expected %0d", sf1, STATS); end
    n_cmp++; if (se1 !== 32'd0) begin n_bad++; $display("FAIL sat_stat_errors: got %0d expected 0", se1); end
    $display("saturation frame of 70000 words done");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_gap_violation();
    test_lane_en();
    test_reset_midframe();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
